// File: rtl/floats.sv
// Shared floating-point definitions: format enum, per-format constants and the
// request bundle handed from the arithmetic datapath to the normalize/round stage.
package floats;

  typedef enum logic [1:0] {
    HALF   = 2'd0,
    SINGLE = 2'd1,
    DOUBLE = 2'd2
  } float_type_e;

  // Index 3 (unknown encoding) aliases DOUBLE.
  localparam int FRAC_W  [4] = '{10, 23, 52, 52};
  localparam int EXP_W   [4] = '{5, 8, 11, 11};
  localparam int BIAS    [4] = '{15, 127, 1023, 1023};
  localparam int EXP_MAX [4] = '{31, 255, 2047, 2047};

  typedef struct packed {
    float_type_e ftype;
    logic        sign;
    logic [12:0] exp;
    logic [64:0] mant;
  } norm_req_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_ROUND  = 3'd2,
`ifdef FPU_SUBNORMAL_EN
    ST_DENORM = 3'd3,
`endif
    ST_PACK   = 3'd4,
    ST_OUT    = 3'd5
  } norm_state_e;

  function automatic float_type_e fmt_of(input logic [1:0] t);
    return (t == 2'd3) ? DOUBLE : float_type_e'(t);
  endfunction

  // Bit position of the result LSB inside the 64-bit left-aligned mantissa.
  function automatic logic [5:0] lsb_pos(input float_type_e t);
    return 6'(63 - FRAC_W[int'(t)]);
  endfunction

  function automatic logic signed [14:0] exp_max(input float_type_e t);
    return 15'(EXP_MAX[int'(t)]);
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational 64-bit leading-zero counter; reports 64 for an all-zero word.
module fpu_lzc (
  input  logic [63:0] i_data,
  output logic [6:0]  o_count
);

  always_comb begin
    o_count = 7'd64;
    // Ascending scan: the highest set bit is the last one to write the count.
    for (int i = 0; i < 64; i++) begin
      if (i_data[i]) o_count = 7'(63 - i);
    end
  end

endmodule

// File: rtl/fpu_normalize_round.sv
// Iterative renormalize + round-to-nearest-even + pack stage, one op in flight.
// FPU_SUBNORMAL_EN adds gradual underflow (DENORM state); otherwise underflow flushes to zero.
module fpu_normalize_round
  import floats::*;
#(
  parameter int SHIFT_STEP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_type,
  input  logic        in_sign,
  input  logic [12:0] in_exp,
  input  logic [64:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [65:0] out_flt,
  output logic        out_inexact,
  output logic [2:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // out_flt/out_inexact stay frozen while out_valid=1 and out_ready=0.

  norm_state_e        r_state, w_state_nxt;
  float_type_e        r_type, w_type_nxt;
  logic               r_sign, w_sign_nxt;
  logic signed [14:0] r_exp, w_exp_nxt;
  logic [64:0]        r_mant, w_mant_nxt;
  logic               r_sticky, w_sticky_nxt;
  logic               r_inexact, w_inexact_nxt;
  logic [65:0]        r_flt, w_flt_nxt;
`ifdef FPU_SUBNORMAL_EN
  logic               r_denorm, w_denorm_nxt;
`endif

  norm_req_t          w_req;
  logic [6:0]         w_lz, w_s;
  logic [5:0]         w_lsb_pos;
  logic [63:0]        w_ulp, w_half, w_keep;
  logic               w_lsb, w_guard, w_stk, w_up;
  logic [64:0]        w_sum, w_rmant;
  logic signed [14:0] w_rexp;
  logic [63:0]        w_val;

  assign w_req = '{ftype: fmt_of(in_type), sign: in_sign, exp: in_exp, mant: in_mant};

  fpu_lzc u_lzc (
    .i_data  (r_mant[63:0]),
    .o_count (w_lz)
  );

  assign w_s = (w_lz < 7'(SHIFT_STEP)) ? w_lz : 7'(SHIFT_STEP);

  // Rounding datapath: keep bits [63:lsb], guard just below, sticky everything lower.
  assign w_lsb_pos = lsb_pos(r_type);
  assign w_ulp     = 64'h1 << w_lsb_pos;
  assign w_half    = w_ulp >> 1;
  assign w_keep    = r_mant[63:0] & ~(w_ulp - 64'h1);
  assign w_lsb     = |(r_mant[63:0] & w_ulp);
  assign w_guard   = |(r_mant[63:0] & w_half);
  assign w_stk     = (|(r_mant[63:0] & (w_half - 64'h1))) | r_sticky;
  assign w_up      = w_guard && (w_stk || w_lsb);
  assign w_sum     = {1'b0, w_keep} + (w_up ? {1'b0, w_ulp} : 65'd0);
  assign w_rmant   = w_sum[64] ? (w_sum >> 1) : w_sum;
  assign w_rexp    = r_exp + {14'd0, w_sum[64]};

  always_comb begin
    w_val = '0;
    case (r_type)
      HALF:    w_val = {48'd0, r_sign, r_exp[4:0], r_mant[62:53]};
      SINGLE:  w_val = {32'd0, r_sign, r_exp[7:0], r_mant[62:40]};
      default: w_val = {r_sign, r_exp[10:0], r_mant[62:11]};
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_type_nxt    = r_type;
    w_sign_nxt    = r_sign;
    w_exp_nxt     = r_exp;
    w_mant_nxt    = r_mant;
    w_sticky_nxt  = r_sticky;
    w_inexact_nxt = r_inexact;
    w_flt_nxt     = r_flt;
`ifdef FPU_SUBNORMAL_EN
    w_denorm_nxt  = r_denorm;
`endif
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_type_nxt    = w_req.ftype;
          w_sign_nxt    = w_req.sign;
          w_exp_nxt     = {{2{w_req.exp[12]}}, w_req.exp};
          w_mant_nxt    = w_req.mant;
          w_sticky_nxt  = 1'b0;
          w_inexact_nxt = 1'b0;
`ifdef FPU_SUBNORMAL_EN
          w_denorm_nxt  = 1'b0;
`endif
          w_state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_mant == 65'd0) begin
          w_exp_nxt   = '0;
          w_state_nxt = ST_PACK;
        end else if (r_mant[64]) begin
          w_mant_nxt   = r_mant >> 1;
          w_sticky_nxt = r_sticky | r_mant[0];
          w_exp_nxt    = r_exp + 15'sd1;
          w_state_nxt  = ST_ROUND;
        end else if (r_mant[63]) begin
          w_state_nxt = ST_ROUND;
        end else begin
          w_mant_nxt = {1'b0, r_mant[63:0] << w_s};
          w_exp_nxt  = r_exp - {8'd0, w_s};
        end
      end
      ST_ROUND: begin
        w_state_nxt   = ST_PACK;
        w_inexact_nxt = w_guard | w_stk;
`ifdef FPU_SUBNORMAL_EN
        if (r_denorm) begin
          // A carry into the hidden bit promotes the subnormal to the smallest normal.
          w_mant_nxt = w_rmant;
          w_exp_nxt  = w_rmant[63] ? 15'sd1 : 15'sd0;
        end else
`endif
        if (w_rexp >= exp_max(r_type)) begin
          w_exp_nxt     = exp_max(r_type);
          w_mant_nxt    = {2'b01, 63'd0};
          w_inexact_nxt = 1'b1;
        end else if (w_rexp <= 15'sd0) begin
`ifdef FPU_SUBNORMAL_EN
          // Denormalize from the unrounded mantissa to avoid rounding twice.
          w_inexact_nxt = r_inexact;
          w_state_nxt   = ST_DENORM;
`else
          w_exp_nxt     = '0;
          w_mant_nxt    = '0;
          w_inexact_nxt = 1'b1;
`endif
        end else begin
          w_mant_nxt = w_rmant;
          w_exp_nxt  = w_rexp;
        end
      end
`ifdef FPU_SUBNORMAL_EN
      ST_DENORM: begin
        if (r_exp >= 15'sd1 || r_mant == 65'd0) begin
          w_denorm_nxt = 1'b1;
          w_state_nxt  = ST_ROUND;
        end else begin
          w_mant_nxt   = r_mant >> 1;
          w_sticky_nxt = r_sticky | r_mant[0];
          w_exp_nxt    = r_exp + 15'sd1;
        end
      end
`endif
      ST_PACK: begin
        w_flt_nxt   = {r_type, w_val};
        w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_type    <= HALF;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_mant    <= '0;
      r_sticky  <= 1'b0;
      r_inexact <= 1'b0;
      r_flt     <= '0;
`ifdef FPU_SUBNORMAL_EN
      r_denorm  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_type    <= w_type_nxt;
      r_sign    <= w_sign_nxt;
      r_exp     <= w_exp_nxt;
      r_mant    <= w_mant_nxt;
      r_sticky  <= w_sticky_nxt;
      r_inexact <= w_inexact_nxt;
      r_flt     <= w_flt_nxt;
`ifdef FPU_SUBNORMAL_EN
      r_denorm  <= w_denorm_nxt;
`endif
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_OUT);
  assign out_flt     = r_flt;
  assign out_inexact = r_inexact;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fpu_normalize_round.sv
// Directed bench for fpu_normalize_round: hand-computed vectors, latency,
// output hold under backpressure and asynchronous reset mid-operation.
module tb_fpu_normalize_round;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_type;
  logic        in_sign;
  logic [12:0] in_exp;
  logic [64:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [65:0] out_flt;
  logic        out_inexact;
  logic [2:0]  dbg_state;

  int          n_checks;
  int          n_errors;
  logic [65:0] exp_q[$];
  logic [65:0] held;

  fpu_normalize_round #(.SHIFT_STEP(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_type     (in_type),
    .in_sign     (in_sign),
    .in_exp      (in_exp),
    .in_mant     (in_mant),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_flt     (out_flt),
    .out_inexact (out_inexact),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] t, input logic s,
                        input logic [12:0] e, input logic [64:0] m,
                        input logic [65:0] exp_flt, input logic exp_inx, input int exp_lat);
    int          lat;
    logic [65:0] expv;
    exp_q.push_back(exp_flt);
    @(negedge clk);
    check({tag, "_rdy"}, {65'd0, in_ready}, 66'd1);
    in_valid = 1'b1; in_type = t; in_sign = s; in_exp = e; in_mant = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, {65'd0, in_ready}, 66'd0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 66'(lat), 66'(exp_lat));
    expv = exp_q.pop_front();
    check({tag, "_flt"}, out_flt, expv);
    check({tag, "_inx"}, {65'd0, out_inexact}, {65'd0, exp_inx});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_done"}, {64'd0, out_valid, in_ready}, 66'b01);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_type = 2'd0; in_sign = 1'b0;
    in_exp = '0; in_mant = '0; out_ready = 1'b0;
    #12;
    check("rst_ready", {65'd0, in_ready}, 66'd1);
    check("rst_valid", {65'd0, out_valid}, 66'd0);
    check("rst_flt", out_flt, 66'd0);
    check("rst_inx", {65'd0, out_inexact}, 66'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("one",   2'd1, 1'b0, 13'd127, 65'h0_8000_0000_0000_0000, {2'b01, 64'h3F80_0000}, 1'b0, 3);
    run_op("carry", 2'd1, 1'b0, 13'd127, 65'h1_0000_0000_0000_0000, {2'b01, 64'h4000_0000}, 1'b0, 3);
    run_op("dshft", 2'd2, 1'b0, 13'd1023, 65'h0_0000_0001_0000_0000, {2'b10, 64'h3E00_0000_0000_0000}, 1'b0, 7);
    run_op("sshft", 2'd1, 1'b0, 13'd130, 65'h0_0100_0000_0000_0000, {2'b01, 64'h3D80_0000}, 1'b0, 4);
    run_op("tie",   2'd1, 1'b0, 13'd127, 65'h0_8000_0080_0000_0000, {2'b01, 64'h3F80_0000}, 1'b1, 3);
    run_op("rup",   2'd1, 1'b0, 13'd127, 65'h0_8000_0180_0000_0000, {2'b01, 64'h3F80_0002}, 1'b1, 3);
    run_op("rcar",  2'd1, 1'b0, 13'd127, 65'h0_FFFF_FF80_0000_0000, {2'b01, 64'h4000_0000}, 1'b1, 3);
    run_op("hinf",  2'd0, 1'b0, 13'd31,  65'h0_8000_0000_0000_0000, {2'b00, 64'h7C00}, 1'b1, 3);
    run_op("sinf",  2'd1, 1'b0, 13'd255, 65'h0_8000_0000_0000_0000, {2'b01, 64'h7F80_0000}, 1'b1, 3);
    run_op("hneg",  2'd0, 1'b1, 13'd15,  65'h0_8020_0000_0000_0000, {2'b00, 64'hBC01}, 1'b0, 3);
    run_op("dzero", 2'd2, 1'b1, 13'd100, 65'h0, {2'b10, 64'h8000_0000_0000_0000}, 1'b0, 2);
    run_op("type3", 2'd3, 1'b0, 13'd1023, 65'h0_8000_0000_0000_0000, {2'b10, 64'h3FF0_0000_0000_0000}, 1'b0, 3);
`ifdef FPU_SUBNORMAL_EN
    run_op("uflow", 2'd1, 1'b0, 13'h1FFB, 65'h0_8000_0000_0000_0000, {2'b01, 64'h0002_0000}, 1'b0, 11);
`else
    run_op("uflow", 2'd1, 1'b0, 13'h1FFB, 65'h0_8000_0000_0000_0000, {2'b01, 64'h0}, 1'b1, 3);
`endif

    // Backpressure: result held, new requests refused while waiting for out_ready.
    @(negedge clk);
    in_valid = 1'b1; in_type = 2'd1; in_sign = 1'b0; in_exp = 13'd127;
    in_mant = 65'h0_8000_0000_0000_0000;
    @(posedge clk); #1;
    in_mant = 65'h0_C000_0000_0000_0000;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    check("bp_valid", {65'd0, out_valid}, 66'd1);
    held = out_flt;
    check("bp_first", held, {2'b01, 64'h3F80_0000});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {out_flt, out_valid, in_ready}, {2'b01, 64'h3F80_0000, 1'b1, 1'b0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    check("bp_noacc", {64'd0, out_valid, in_ready}, 66'b01);

    // Asynchronous reset while shifting abandons the operation.
    @(negedge clk);
    in_valid = 1'b1; in_type = 2'd2; in_sign = 1'b0; in_exp = 13'd1023; in_mant = 65'h1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rs_shift", {63'd0, dbg_state}, 66'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_now", {64'd0, out_valid, in_ready}, 66'b01);
    check("rs_flt", out_flt, 66'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    check("rs_quiet", {64'd0, out_valid, in_ready}, 66'b01);
    run_op("rs_again", 2'd1, 1'b1, 13'd127, 65'h0_8000_0000_0000_0000, {2'b01, 64'hBF80_0000}, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
